// File: rtl/note_cmd_if.sv
// note_cmd_if: byte handshake from uart_rx plus the note/volume/gate outputs
// of note_cmd_parser. The master modport is the uart_rx/consumer side, the
// slave modport is the parser.
interface note_cmd_if;
    logic [7:0] d_in;
    logic       ready;
    logic       ack;
    logic [7:0] note;
    logic [7:0] volume;
    logic       gate;
    logic       note_strobe;
    logic       err;

    modport master (
        output d_in, ready,
        input  ack, note, volume, gate, note_strobe, err
    );

    modport slave (
        input  d_in, ready,
        output ack, note, volume, gate, note_strobe, err
    );
endinterface

// File: rtl/note_cmd_parser.sv
// note_cmd_parser: drains bytes from uart_rx and decodes MIDI-style
// note-on (0x9n) / note-off (0x8n) messages into a mono note, volume and gate.
// Optional feature macro: NOTE_CMD_RUNNING_STATUS_EN (running status).
//
// Handshake: uart_rx holds ready high with a byte on d_in until acknowledged.
// A byte is taken in a cycle where ready=1, ack=0 and holdoff=0; ack is high
// for exactly the following cycle and holdoff for the cycle after that, so a
// ready that drops one cycle late is never mistaken for a second byte.
module note_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    note_cmd_if.slave  bus,
    output logic [1:0] o_dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GET_NOTE = 2'd1,
        S_GET_VEL  = 2'd2,
        S_SKIP     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ack;
    logic             r_holdoff;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_kind_on;
    logic [7:0]       r_note_num;
    logic [7:0]       r_note;
    logic [7:0]       r_volume;
    logic             r_gate;
    logic             r_strobe;
    logic             r_err;

    // Byte classification and event decode
    logic w_accept;
    logic w_is_status;
    logic w_is_rt;
    logic w_is_supp;
    logic w_in_msg;
    logic w_timeout;
    logic w_byte;
    logic w_new_status;
    logic w_abort;
    logic w_data;
    logic w_rs_valid;
    logic w_rs_on;

    // Actions produced by the output process
    logic w_rs_start;
    logic w_latch_note;
    logic w_exec;
    logic w_exec_on;
    logic w_exec_off;

    assign w_accept     = bus.ready & ~r_ack & ~r_holdoff;
    assign w_is_status  = bus.d_in[7];
    assign w_is_rt      = &bus.d_in[7:3];
    assign w_is_supp    = (bus.d_in[7:5] == 3'b100);
    assign w_in_msg     = (r_state == S_GET_NOTE) || (r_state == S_GET_VEL);
    // An accepted byte in the same cycle always beats the timeout.
    assign w_timeout    = w_in_msg & ~w_accept & (r_tmo_cnt == TMO_MAX);
    // Real-time bytes are acknowledged but otherwise invisible to the FSM.
    assign w_byte       = w_accept & ~w_is_rt;
    assign w_new_status = w_byte & w_is_status & w_is_supp;
    assign w_abort      = w_byte & w_is_status & w_in_msg;
    assign w_data       = w_byte & ~w_is_status;

`ifdef NOTE_CMD_RUNNING_STATUS_EN
    logic r_rs_valid;
    logic r_rs_on;
    logic w_rs_clr;

    assign w_rs_clr = w_timeout | w_abort | (w_byte & w_is_status & ~w_is_supp);

    // Remember the last supported status; a new one wins over a same-cycle abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_valid <= 1'b0;
            r_rs_on    <= 1'b0;
        end else if (w_new_status) begin
            r_rs_valid <= 1'b1;
            r_rs_on    <= bus.d_in[4];
        end else if (w_rs_clr) begin
            r_rs_valid <= 1'b0;
        end
    end

    assign w_rs_valid = r_rs_valid;
    assign w_rs_on    = r_rs_on;
`else
    assign w_rs_valid = 1'b0;
    assign w_rs_on    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; a status byte always restarts decoding as from IDLE
    always_comb begin
        w_next_state = r_state;
        if (w_timeout) begin
            w_next_state = S_IDLE;
        end else if (w_byte && w_is_status) begin
            w_next_state = w_is_supp ? S_GET_NOTE : S_SKIP;
        end else if (w_data) begin
            case (r_state)
                S_IDLE:     w_next_state = w_rs_valid ? S_GET_VEL : S_IDLE;
                S_GET_NOTE: w_next_state = S_GET_VEL;
                S_GET_VEL:  w_next_state = S_IDLE;
                default:    w_next_state = S_SKIP;
            endcase
        end
    end

    // Output/action logic: which registers the current byte updates
    always_comb begin
        w_rs_start   = w_data && (r_state == S_IDLE) && w_rs_valid;
        w_latch_note = w_data && ((r_state == S_GET_NOTE) || w_rs_start);
        w_exec       = w_data && (r_state == S_GET_VEL);
        w_exec_on    = w_exec && r_kind_on && (bus.d_in[6:0] != 7'd0) && (r_note_num != 8'd0);
        // Off only silences the note that is actually sounding.
        w_exec_off   = w_exec && !w_exec_on && r_gate && (r_note_num == r_note);
    end

    // Byte handshake: one-cycle ack followed by one holdoff cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_holdoff <= 1'b0;
        end else begin
            r_ack     <= w_accept;
            r_holdoff <= r_ack;
        end
    end

    // Inter-byte timeout counter, only running inside a message
    always_ff @(posedge clk) begin
        if (!rst_n || !w_in_msg || w_accept || w_timeout) r_tmo_cnt <= '0;
        else                                            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    // Message context: status kind and note number
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kind_on  <= 1'b0;
            r_note_num <= 8'd0;
        end else begin
            if (w_new_status)    r_kind_on <= bus.d_in[4];
            else if (w_rs_start) r_kind_on <= w_rs_on;
            if (w_latch_note)    r_note_num <= {1'b0, bus.d_in[6:0]};
        end
    end

    // Sounding note, volume, gate and the change/error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_note   <= 8'd0;
            r_volume <= 8'd0;
            r_gate   <= 1'b0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= w_exec_on | w_exec_off;
            r_err    <= w_abort | w_timeout;
            if (w_exec_on) begin
                r_note   <= r_note_num;
                r_volume <= {bus.d_in[6:0], 1'b0};
                r_gate   <= 1'b1;
            end else if (w_exec_off) begin
                r_note   <= 8'd0;
                r_volume <= 8'd0;
                r_gate   <= 1'b0;
            end
        end
    end

    assign bus.ack         = r_ack;
    assign bus.note        = r_note;
    assign bus.volume      = r_volume;
    assign bus.gate        = r_gate;
    assign bus.note_strobe = r_strobe;
    assign bus.err         = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_note_cmd_parser.sv
// tb_note_cmd_parser: table-driven byte sequences with a strobe scoreboard,
// plus hand-written timeout and reset sequences.
module tb_note_cmd_parser;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    note_cmd_if bus();

    note_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [6];
        int          n;
        int          n_strobe;
        logic [16:0] mid;
        logic [16:0] fin;
        int          n_err;
    } vec_t;

    vec_t        vecs [$];
    logic [16:0] exp_q [$];

    int   n_vec = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    int   ack_cnt = 0;
    logic prev_ack = 1'b0;
    logic prev_err = 1'b0;
    logic prev_strobe = 1'b0;

    function automatic logic [16:0] mk(input logic [7:0] n, input logic [7:0] v, input logic g);
        return {n, v, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One clock, then sample outputs 1 time unit after the edge
    task automatic step();
        logic [16:0] e;
        @(posedge clk);
        #1;
        if (prev_ack)    check("ack_width", {31'd0, bus.ack}, 32'd0);
        if (prev_err)    check("err_width", {31'd0, bus.err}, 32'd0);
        if (prev_strobe) check("strobe_width", {31'd0, bus.note_strobe}, 32'd0);
        if (bus.note_strobe) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_strobe: got note 0x%0h volume 0x%0h gate %0d, required no strobe",
                         bus.note, bus.volume, bus.gate);
            end else begin
                e = exp_q.pop_front();
                check("strobe_out", {15'd0, bus.note, bus.volume, bus.gate}, {15'd0, e});
            end
        end
        if (bus.ack && !prev_ack) ack_cnt++;
        if (bus.err && !prev_err) err_cnt++;
        prev_ack    = bus.ack;
        prev_err    = bus.err;
        prev_strobe = bus.note_strobe;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.d_in  = b;
        bus.ready = 1'b1;
        step();
        check("ack_latency", {31'd0, bus.ack}, 32'd1);
        bus.ready = 1'b0;
        step();
        step();
    endtask

    task automatic add(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                       input int n, input int ns, input logic [16:0] mid,
                       input logic [16:0] fin, input int ne);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
        v.n = n; v.n_strobe = ns; v.mid = mid; v.fin = fin; v.n_err = ne;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int e0;
        int a0;
        e0 = err_cnt;
        a0 = ack_cnt;
        if (v.n_strobe == 2) exp_q.push_back(v.mid);
        if (v.n_strobe >= 1) exp_q.push_back(v.fin);
        for (int i = 0; i < v.n; i++) send_byte(v.b[i]);
        idle(2);
        check("vec_out", {15'd0, bus.note, bus.volume, bus.gate}, {15'd0, v.fin});
        check("vec_err", err_cnt - e0, v.n_err);
        check("vec_acks", ack_cnt - a0, v.n);
        check("vec_strobes_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int          e0;
        int          waited;
        logic        seen;
        logic [16:0] silent;
        logic [16:0] cur;
        silent = mk(8'h00, 8'h00, 1'b0);

        // Table, applied in order; each row starts from the previous row's state
        add(8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00, 3, 1, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        add(8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 3, 0, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        add(8'h80, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1, silent, silent, 0);
        add(8'h90, 8'h3C, 8'h90, 8'h45, 8'h7F, 8'h00, 5, 1, silent, mk(8'h45, 8'hFE, 1'b1), 1);
        add(8'h90, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 3, 0, silent, mk(8'h45, 8'hFE, 1'b1), 0);
        add(8'h90, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1, silent, silent, 0);
        add(8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 8'h00, 5, 1, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        add(8'hB0, 8'h07, 8'h40, 8'h00, 8'h00, 8'h00, 3, 0, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        add(8'h90, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 3, 0, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        add(8'h91, 8'h50, 8'h7F, 8'h00, 8'h00, 8'h00, 3, 1, silent, mk(8'h50, 8'hFE, 1'b1), 0);
`ifdef NOTE_CMD_RUNNING_STATUS_EN
        add(8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h00, 5, 2, mk(8'h3C, 8'hC8, 1'b1), mk(8'h40, 8'hA0, 1'b1), 0);
        cur = mk(8'h40, 8'hA0, 1'b1);
`else
        add(8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h00, 5, 1, silent, mk(8'h3C, 8'hC8, 1'b1), 0);
        cur = mk(8'h3C, 8'hC8, 1'b1);
`endif
        add(8'hF2, 8'h10, 8'h20, 8'h90, 8'h22, 8'h33, 6, 1, silent, mk(8'h22, 8'h66, 1'b1), 0);
        add(8'h90, 8'h3C, 8'hF2, 8'h55, 8'h00, 8'h00, 4, 0, silent, mk(8'h22, 8'h66, 1'b1), 1);
        add(8'h3C, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, silent, mk(8'h22, 8'h66, 1'b1), 0);

        // Reset values
        bus.d_in  = 8'h00;
        bus.ready = 1'b0;
        rst_n     = 1'b0;
        idle(3);
        check("reset_outputs", {20'd0, bus.ack, bus.note, bus.volume, bus.gate, bus.note_strobe, bus.err}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        cur = mk(8'h22, 8'h66, 1'b1);

        // Timeout: a lone 0x90 must abort with err; later data changes nothing
        e0 = err_cnt;
        send_byte(8'h90);
        waited = 0;
        seen   = 1'b0;
        for (int i = 0; i < TMO + 10 && !seen; i++) begin
            step();
            waited++;
            if (err_cnt > e0) seen = 1'b1;
        end
        check("timeout_err_seen", {31'd0, seen}, 32'd1);
        check("timeout_window", {31'd0, (waited >= TMO - 3) && (waited <= TMO + 1)}, 32'd1);
        check("timeout_state_idle", {30'd0, dbg_state}, 32'd0);
        send_byte(8'h3C);
        send_byte(8'h64);
        idle(2);
        check("after_timeout_out", {15'd0, bus.note, bus.volume, bus.gate}, {15'd0, cur});
        check("after_timeout_err", err_cnt - e0, 1);

        // Bytes spaced just under the timeout keep the message alive
        e0 = err_cnt;
        exp_q.push_back(mk(8'h30, 8'h20, 1'b1));
        send_byte(8'h90);
        idle(TMO - 8);
        send_byte(8'h30);
        idle(TMO - 8);
        send_byte(8'h10);
        idle(2);
        check("slow_msg_out", {15'd0, bus.note, bus.volume, bus.gate}, {15'd0, mk(8'h30, 8'h20, 1'b1)});
        check("slow_msg_err", err_cnt - e0, 0);
        check("slow_msg_strobe", exp_q.size(), 0);
        exp_q.delete();

        // Reset mid-message drops the partial message and clears the outputs
        send_byte(8'h90);
        send_byte(8'h3C);
        rst_n = 1'b0;
        step();
        check("midreset_outputs", {20'd0, bus.ack, bus.note, bus.volume, bus.gate, bus.note_strobe, bus.err}, 32'd0);
        check("midreset_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        step();
        send_byte(8'h64);
        idle(2);
        check("after_reset_out", {15'd0, bus.note, bus.volume, bus.gate}, {15'd0, silent});
        check("after_reset_state", {30'd0, dbg_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
